// File: rtl/vc_mem_rand_delay_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : vc_mem_rand_delay_responder_if
//  Description : val/rdy memory request/response bundle. The master drives
//                requests and accepts responses; the slave serves requests.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vc_mem_rand_delay_responder_if;

    logic        memreq_val;
    logic        memreq_rdy;
    logic [66:0] memreq_msg;
    logic        memresp_val;
    logic        memresp_rdy;
    logic [34:0] memresp_msg;

    modport master (
        output memreq_val,
        input  memreq_rdy,
        output memreq_msg,
        input  memresp_val,
        output memresp_rdy,
        input  memresp_msg
    );

    modport slave (
        input  memreq_val,
        output memreq_rdy,
        input  memreq_msg,
        output memresp_val,
        input  memresp_rdy,
        output memresp_msg
    );

endinterface
`default_nettype wire

// File: rtl/vc_mem_rand_delay_responder.sv
`default_nettype none
// ============================================================================
//  Module      : vc_mem_rand_delay_responder
//  Description : Single-port word memory behind a val/rdy request/response
//                port. Responses return in order through a 2-entry buffer,
//                each held back by an LFSR-driven extra delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module vc_mem_rand_delay_responder #(
    parameter int          P_MEM_SZ    = 1 << 20,
    parameter int          P_MAX_DELAY = 0,
    parameter logic [15:0] P_SEED      = 16'hACE1
) (
    input  wire logic                        clk,
    input  wire logic                        reset,
    vc_mem_rand_delay_responder_if.slave     mem
);

    localparam int C_WORDS = P_MEM_SZ / 4;
    localparam int C_IDX_W = (C_WORDS > 1) ? $clog2(C_WORDS) : 1;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    // Word array; left out of reset so preloaded / written contents survive.
    logic [31:0] m [0:C_WORDS-1];

    state_t       r_state;
    state_t       w_state_next;
    logic [7:0]   r_delay;
    logic [7:0]   w_delay_next;
    logic [1:0]   r_count;
    logic [1:0]   w_count_next;
    logic [15:0]  r_lfsr;
    logic [15:0]  w_lfsr_step;
    logic [7:0]   w_load_val;
    logic [34:0]  r_ent0;
    logic [34:0]  r_ent1;

    logic         w_rdy;
    logic         w_acc;
    logic         w_deq;
    logic         w_load;
    logic         w_typ;
    logic [31:0]  w_addr;
    logic [1:0]   w_len;
    logic [31:0]  w_data;
    logic [1:0]   w_off;
    logic [C_IDX_W-1:0] w_idx;
    logic [3:0]   w_nmask;
    logic [3:0]   w_be;
    logic [31:0]  w_wsh;
    logic [31:0]  w_rword;
    logic [31:0]  w_rsh;
    logic [31:0]  w_dmask;
    logic [31:0]  w_rdata;
    logic [34:0]  w_resp;

    // Request field split and address decode (upper bits wrap).
    assign w_typ  = mem.memreq_msg[66];
    assign w_addr = mem.memreq_msg[65:34];
    assign w_len  = mem.memreq_msg[33:32];
    assign w_data = mem.memreq_msg[31:0];
    assign w_off  = w_addr[1:0];
    assign w_idx  = C_IDX_W'((w_addr >> 2) & 32'(C_WORDS - 1));

    // Ready comes from the registered occupancy only, never from a same-cycle dequeue.
    assign w_rdy  = !reset && (r_count < 2'd2);
    assign w_acc  = mem.memreq_val && w_rdy;
    assign w_deq  = (r_state == S_VALID) && mem.memresp_rdy;

    // Byte-count mask: len 0 means a full word.
    always_comb begin
        w_nmask = 4'b1111;
        case (w_len)
            2'd1:    w_nmask = 4'b0001;
            2'd2:    w_nmask = 4'b0011;
            2'd3:    w_nmask = 4'b0111;
            default: w_nmask = 4'b1111;
        endcase
    end

    // Lanes shifted past lane 3 fall off the top, so accesses never spill.
    assign w_be    = w_nmask << w_off;
    assign w_wsh   = w_data << {w_off, 3'b000};
    assign w_rword = m[w_idx];
    assign w_rsh   = w_rword >> {w_off, 3'b000};
    assign w_dmask = {{8{w_nmask[3]}}, {8{w_nmask[2]}}, {8{w_nmask[1]}}, {8{w_nmask[0]}}};
    assign w_rdata = w_rsh & w_dmask;
    assign w_resp  = {w_typ, w_len, (w_typ ? 32'd0 : w_rdata)};

    // Byte-lane writes land at the accept edge.
    always_ff @(posedge clk) begin
        if (w_acc && w_typ) begin
            for (int l = 0; l < 4; l++) begin
                if (w_be[l]) begin
                    m[w_idx][8*l +: 8] <= w_wsh[8*l +: 8];
                end
            end
        end
    end

    // Fibonacci LFSR, taps 16,14,13,11 (bit 0 is the output end).
    assign w_lfsr_step = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

    generate
        if (P_MAX_DELAY == 0) begin : g_no_delay
            assign w_load_val = 8'd0;
        end else begin : g_rand_delay
            logic [15:0] w_mod;
            assign w_mod      = r_lfsr % 16'(P_MAX_DELAY + 1);
            assign w_load_val = w_mod[7:0];
        end
    endgenerate

    // A new head appears on enqueue into empty or dequeue with an entry behind.
    assign w_load = (w_acc && (r_count == 2'd0)) ||
                    (w_deq && ((r_count == 2'd2) || w_acc));

    assign w_count_next = r_count + {1'b0, w_acc} - {1'b0, w_deq};

    // Head state machine: next state and delay counter.
    always_comb begin
        w_state_next = r_state;
        w_delay_next = r_delay;
        case (r_state)
            S_EMPTY: begin
                if (w_load) begin
                    w_delay_next = w_load_val;
                    w_state_next = (w_load_val == 8'd0) ? S_VALID : S_WAIT;
                end
            end
            S_WAIT: begin
                w_delay_next = r_delay - 8'd1;
                w_state_next = (r_delay == 8'd1) ? S_VALID : S_WAIT;
            end
            S_VALID: begin
                if (w_deq) begin
                    if (w_load) begin
                        w_delay_next = w_load_val;
                        w_state_next = (w_load_val == 8'd0) ? S_VALID : S_WAIT;
                    end else begin
                        w_state_next = S_EMPTY;
                    end
                end
            end
            default: begin
                w_state_next = S_EMPTY;
                w_delay_next = 8'd0;
            end
        endcase
    end

    // State, counters, LFSR and the two-entry response buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_delay <= 8'd0;
            r_count <= 2'd0;
            r_lfsr  <= P_SEED;
            r_ent0  <= '0;
            r_ent1  <= '0;
        end else begin
            r_state <= w_state_next;
            r_delay <= w_delay_next;
            r_count <= w_count_next;
            if (w_load) begin
                r_lfsr <= w_lfsr_step;
            end
            if (w_deq) begin
                if (r_count == 2'd2) begin
                    r_ent0 <= r_ent1;
                end else if (w_acc) begin
                    r_ent0 <= w_resp;
                end
            end else if (w_acc) begin
                if (r_count == 2'd0) begin
                    r_ent0 <= w_resp;
                end else begin
                    r_ent1 <= w_resp;
                end
            end
        end
    end

    assign mem.memreq_rdy  = w_rdy;
    assign mem.memresp_val = (r_state == S_VALID);
    assign mem.memresp_msg = r_ent0;

endmodule
`default_nettype wire
